// File: rtl/dir_tx.sv
// dir_tx: UART transmitter that sends the local snake direction once per game tick.
// Define DIR_TX_PARITY_EN for an even-parity bit (8E1); default build is 8N1.
package snake_pkg;
   typedef enum logic [2:0] {
      NONE  = 3'd0,
      UP    = 3'd1,
      DOWN  = 3'd2,
      RIGHT = 3'd3,
      LEFT  = 3'd4
   } direction_t;
endpackage

module dir_tx
   import snake_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_div,
   input  direction_t dir1,
   output logic       tx,
   output logic       busy,
   output logic       sent,
   output logic       overrun
);
   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;

`ifdef DIR_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    pend_q, pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic          ovr_q, ovr_d;
   logic          clk_div_prv_q;

   logic          tick;
   logic          baud_last;
   logic [7:0]    new_b;

   function automatic logic [7:0] enc(input direction_t d);
      case (d)
         UP:      enc = 8'hA1;
         DOWN:    enc = 8'hA2;
         RIGHT:   enc = 8'hA3;
         LEFT:    enc = 8'hA4;
         default: enc = 8'hA0;
      endcase
   endfunction

   assign tick      = clk_div & ~clk_div_prv_q;
   assign baud_last = (baud_q == CW'(CPB - 1));
   assign new_b     = enc(dir1);

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      data_d     = data_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      ovr_d      = ovr_q;
      if (state_q != IDLE) begin
         baud_d = baud_last ? '0 : baud_q + CW'(1);
      end
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = START;
               data_d  = new_b;
               baud_d  = '0;
            end
         end
         START: begin
            if (baud_last) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (baud_last) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef DIR_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef DIR_TX_PARITY_EN
         PARITY: begin
            if (baud_last) state_d = STOP;
         end
`endif
         STOP: begin
            if (baud_last) begin
               // Pending byte goes first; a same-cycle tick refills pending.
               if (pend_vld_q) begin
                  state_d = START;
                  data_d  = pend_q;
                  if (tick) pend_d = new_b;
                  else pend_vld_d = 1'b0;
               end else if (tick) begin
                  state_d = START;
                  data_d  = new_b;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (tick && (state_q != IDLE) && !((state_q == STOP) && baud_last)) begin
         if (pend_vld_q) ovr_d = 1'b1;
         pend_d     = new_b;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         baud_q        <= '0;
         bit_q         <= '0;
         data_q        <= '0;
         pend_q        <= '0;
         pend_vld_q    <= 1'b0;
         ovr_q         <= 1'b0;
         clk_div_prv_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         baud_q        <= baud_d;
         bit_q         <= bit_d;
         data_q        <= data_d;
         pend_q        <= pend_d;
         pend_vld_q    <= pend_vld_d;
         ovr_q         <= ovr_d;
         clk_div_prv_q <= clk_div;
      end
   end

   always_comb begin
      tx = 1'b1;
      unique case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = data_q[bit_q];
`ifdef DIR_TX_PARITY_EN
         PARITY:  tx = ^data_q;
`endif
         default: tx = 1'b1;
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign sent    = (state_q == STOP) && baud_last;
   assign overrun = ovr_q;
endmodule
